// File: rtl/match_controller_if.sv
// Player keys in, playfield/score/status out for the tug-of-war match controller.
//   L, R        : synchronized player key levels (driven toward the controller)
//   lights      : one-hot lit position, bit LIGHTS-1 = left end, bit 0 = right end
//   round_reset : high while the field is held between rounds
//   score_l/_r  : per-player round scores
//   winner      : last round winner, 00 none, 01 left, 10 right
//   game_over   : high once a player reaches the target score
interface match_controller_if #(
  parameter int unsigned LIGHTS = 9
);
  logic              L;
  logic              R;
  logic [LIGHTS-1:0] lights;
  logic              round_reset;
  logic [2:0]        score_l;
  logic [2:0]        score_r;
  logic [1:0]        winner;
  logic              game_over;

  // Key source / display sink side
  modport master (
    output L, R,
    input  lights, round_reset, score_l, score_r, winner, game_over
  );

  // Match controller side
  modport slave (
    input  L, R,
    output lights, round_reset, score_l, score_r, winner, game_over
  );
endinterface

// File: rtl/match_controller.sv
// Tug-of-war match sequencer: edge-detects and arbitrates the L/R key presses,
// moves the lit position, detects round wins at either end, keeps scores, holds
// the field blank for HOLD_CYCLES between rounds and latches game over.
//   clk   : system clock
//   reset : asynchronous, active-low
//   bus   : match_controller_if slave (L/R in; lights, round_reset, scores,
//           winner, game_over out -- all registered)
module match_controller #(
  parameter int unsigned LIGHTS      = 9,
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  match_controller_if.slave   bus
);

  localparam int unsigned CENTRE = LIGHTS / 2;
  localparam int unsigned POS_W  = $clog2(LIGHTS);
  localparam int unsigned CNT_W  = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0] ST_PLAY = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q,       state_d;
  logic [POS_W-1:0]  pos_q,         pos_d;
  logic [CNT_W-1:0]  hold_cnt_q,    hold_cnt_d;
  logic [2:0]        score_l_q,     score_l_d;
  logic [2:0]        score_r_q,     score_r_d;
  logic [1:0]        winner_q,      winner_d;
  logic [LIGHTS-1:0] lights_q,      lights_d;
  logic              round_reset_q, round_reset_d;
  logic              game_over_q,   game_over_d;
  logic              l_prev_q;
  logic              r_prev_q;

  logic              press_l;
  logic              press_r;
  logic              round_end;
  logic [2:0]        new_score;

  // State registers; key history is tracked in every state so a held key never re-fires
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_PLAY;
      pos_q         <= POS_W'(CENTRE);
      hold_cnt_q    <= '0;
      score_l_q     <= '0;
      score_r_q     <= '0;
      winner_q      <= 2'b00;
      lights_q      <= LIGHTS'(1) << CENTRE;
      round_reset_q <= 1'b0;
      game_over_q   <= 1'b0;
      l_prev_q      <= 1'b0;
      r_prev_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      hold_cnt_q    <= hold_cnt_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      winner_q      <= winner_d;
      lights_q      <= lights_d;
      round_reset_q <= round_reset_d;
      game_over_q   <= game_over_d;
      l_prev_q      <= bus.L;
      r_prev_q      <= bus.R;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    hold_cnt_d = hold_cnt_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    winner_d   = winner_q;
    round_end  = 1'b0;
    new_score  = '0;

    press_l = bus.L & ~l_prev_q;
    press_r = bus.R & ~r_prev_q;

    case (state_q)
      ST_PLAY: begin
        // Simultaneous presses cancel each other
        if (press_l && !press_r) begin
          if (pos_q == POS_W'(LIGHTS - 1)) begin
            score_l_d = score_l_q + 3'd1;
            winner_d  = 2'b01;
            new_score = score_l_q + 3'd1;
            round_end = 1'b1;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end else if (press_r && !press_l) begin
          if (pos_q == '0) begin
            score_r_d = score_r_q + 3'd1;
            winner_d  = 2'b10;
            new_score = score_r_q + 3'd1;
            round_end = 1'b1;
          end else begin
            pos_d = pos_q - POS_W'(1);
          end
        end
        if (round_end) begin
          if (new_score == 3'(WIN_SCORE)) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_HOLD;
            hold_cnt_d = CNT_W'(HOLD_CYCLES - 1);
          end
        end
      end
      ST_HOLD: begin
        // Counter loaded with HOLD_CYCLES-1 so the hold spans exactly HOLD_CYCLES cycles
        if (hold_cnt_q == '0) begin
          state_d = ST_PLAY;
          pos_d   = POS_W'(CENTRE);
        end else begin
          hold_cnt_d = hold_cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
      end
      default: begin
        state_d = ST_PLAY;
        pos_d   = POS_W'(CENTRE);
      end
    endcase

    // Outputs are registered copies of what the next state presents
    lights_d      = (state_d == ST_PLAY) ? (LIGHTS'(1) << pos_d) : '0;
    round_reset_d = (state_d == ST_HOLD);
    game_over_d   = (state_d == ST_DONE);
  end

  assign bus.lights      = lights_q;
  assign bus.round_reset = round_reset_q;
  assign bus.score_l     = score_l_q;
  assign bus.score_r     = score_r_q;
  assign bus.winner      = winner_q;
  assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: directed match scenarios followed by
// random key traffic with occasional asynchronous resets, all compared against a
// cycle-level model of the match rules.
module tb_match_controller;

  localparam int unsigned LIGHTS = 9;
  localparam int unsigned WIN    = 2;
  localparam int unsigned HOLD   = 4;
  localparam int unsigned CENTRE = LIGHTS / 2;

  localparam int M_PLAY = 0;
  localparam int M_HOLD = 1;
  localparam int M_DONE = 2;

  logic clk = 1'b0;
  logic reset;

  match_controller_if #(.LIGHTS(LIGHTS)) bus();

  match_controller #(
    .LIGHTS      (LIGHTS),
    .WIN_SCORE   (WIN),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model of the match: phase, lit position, remaining hold cycles, scores
  int m_phase;
  int m_pos;
  int m_hold_left;
  int m_sl;
  int m_sr;
  int m_win;
  bit m_lprev;
  bit m_rprev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase     = M_PLAY;
    m_pos       = CENTRE;
    m_hold_left = 0;
    m_sl        = 0;
    m_sr        = 0;
    m_win       = 0;
    m_lprev     = 1'b0;
    m_rprev     = 1'b0;
  endtask

  task automatic model_round_won(input bit left);
    if (left) begin
      m_sl++;
      m_win = 1;
    end else begin
      m_sr++;
      m_win = 2;
    end
    if ((left ? m_sl : m_sr) == WIN) begin
      m_phase = M_DONE;
    end else begin
      m_phase     = M_HOLD;
      m_hold_left = HOLD;
    end
  endtask

  task automatic model_edge(input bit l, input bit r);
    bit pl;
    bit pr;
    pl      = l && !m_lprev;
    pr      = r && !m_rprev;
    m_lprev = l;
    m_rprev = r;
    if (m_phase == M_PLAY) begin
      if (pl && !pr) begin
        if (m_pos == LIGHTS - 1) model_round_won(1'b1);
        else m_pos++;
      end else if (pr && !pl) begin
        if (m_pos == 0) model_round_won(1'b0);
        else m_pos--;
      end
    end else if (m_phase == M_HOLD) begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        m_phase = M_PLAY;
        m_pos   = CENTRE;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_lights;
    exp_lights = (m_phase == M_PLAY) ? (32'd1 << m_pos) : 32'd0;
    chk({tag, ".lights"},      32'(bus.lights),      exp_lights);
    chk({tag, ".round_reset"}, 32'(bus.round_reset), 32'(m_phase == M_HOLD));
    chk({tag, ".game_over"},   32'(bus.game_over),   32'(m_phase == M_DONE));
    chk({tag, ".score_l"},     32'(bus.score_l),     32'(m_sl));
    chk({tag, ".score_r"},     32'(bus.score_r),     32'(m_sr));
    chk({tag, ".winner"},      32'(bus.winner),      32'(m_win));
    // Structural invariants on the outputs themselves
    chk({tag, ".lights_shape"},
        32'((bus.round_reset || bus.game_over) ? (bus.lights == '0) : $onehot(bus.lights)),
        32'd1);
    chk({tag, ".score_bound"},
        32'((32'(bus.score_l) <= WIN) && (32'(bus.score_r) <= WIN)), 32'd1);
  endtask

  task automatic step(input bit l, input bit r);
    bus.L = l;
    bus.R = r;
    @(posedge clk);
    if (reset) model_edge(l, r);
    #1;
    check_all("step");
  endtask

  // Called 1 time unit after a rising edge: asserts reset mid-cycle, checks, releases
  task automatic async_reset();
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.lights_centre", 32'(bus.lights), 32'h010);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    bus.L = 1'b0;
    bus.R = 1'b0;
    model_reset();
    #12;
    check_all("por");
    chk("por.lights_centre", 32'(bus.lights), 32'h010);
    #1;
    reset = 1'b1;

    // 1: left walks to the end and wins a round, then the hold
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      chk("t1.walk", 32'(bus.lights), 32'h010 << (i + 1));
      step(1'b0, 1'b0);
    end
    step(1'b1, 1'b0);
    chk("t1.score_l", 32'(bus.score_l), 32'd1);
    chk("t1.winner", 32'(bus.winner), 32'd1);
    chk("t1.rr_first", 32'(bus.round_reset), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      chk("t1.rr_held", 32'(bus.round_reset), 32'd1);
    end
    step(1'b0, 1'b0);
    chk("t1.back_centre", 32'(bus.lights), 32'h010);
    chk("t1.rr_clear", 32'(bus.round_reset), 32'd0);

    // 2: simultaneous presses cancel, a held key moves once
    step(1'b1, 1'b1);
    chk("t2.cancel", 32'(bus.lights), 32'h010);
    step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    chk("t2.held_once", 32'(bus.lights), 32'h008);

    // 3: right wins at pos 0, R held through the hold causes no move
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    chk("t3.at_right_end", 32'(bus.lights), 32'h001);
    step(1'b0, 1'b1);
    chk("t3.score_r", 32'(bus.score_r), 32'd1);
    chk("t3.winner", 32'(bus.winner), 32'd2);
    for (int i = 0; i < HOLD + 2; i++) step(1'b0, 1'b1);
    chk("t3.no_move", 32'(bus.lights), 32'h010);

    // 4: left takes the second round and the match; everything freezes
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    chk("t4.score_l", 32'(bus.score_l), 32'd2);
    chk("t4.game_over", 32'(bus.game_over), 32'd1);
    chk("t4.lights_off", 32'(bus.lights), 32'd0);
    for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("t4.frozen_l", 32'(bus.score_l), 32'd2);
    chk("t4.frozen_w", 32'(bus.winner), 32'd1);

    // 5: leave DONE via reset, then reset again in the middle of a hold
    async_reset();
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    chk("t5.in_hold", 32'(bus.round_reset), 32'd1);
    async_reset();
    chk("t5.score_l_cleared", 32'(bus.score_l), 32'd0);
    step(1'b0, 1'b0);
    chk("t5.after_release", 32'(bus.lights), 32'h010);

    // Random key traffic with occasional asynchronous resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0) async_reset();
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
